// File: rtl/wb_write_queue_pkg.sv
// rtl/wb_write_queue_pkg.sv - shared types and defaults for the writeback write queue
package wb_pkg;

  localparam int WB_DW    = 32;
  localparam int WB_AW    = 6;
  localparam int WB_DEPTH = 4;

  localparam logic [WB_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [WB_AW-1:0] rd;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_write_queue_if.sv
// rtl/wb_write_queue_if.sv - request, regfile-write and forwarding signals of the write queue
interface wb_write_queue_if #(
  parameter int DW = 32,
  parameter int AW = 6
);
  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [AW-1:0] lsu_rd;
  logic [DW-1:0] lsu_data;
  logic          wb_hold;
  logic          we3;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd3;
  logic [AW-1:0] fwd_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, wb_hold, fwd_addr,
    input  alu_ready, lsu_ready, we3, a3, wd3, fwd_hit, fwd_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, wb_hold, fwd_addr,
    output alu_ready, lsu_ready, we3, a3, wd3, fwd_hit, fwd_data
  );
endinterface

// File: rtl/wb_write_queue_fifo.sv
// rtl/wb_write_queue_fifo.sv - circular buffer of pending regfile writes
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  wb_entry_t           din_i,
  input  logic                pop_i,
  output wb_entry_t           head_o,
  output logic [PW:0]         count_o,
  output logic [PW-1:0]       head_ptr_o,
  output wb_entry_t           entries_o [DEPTH],
  output logic [DEPTH-1:0]    valid_o,
  output logic                full_o,
  output logic                empty_o
);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: valid_o masks every slot outside the live window.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  always_comb begin
    valid_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entries_o[i] = mem_q[i];
      valid_o[i]   = ({1'b0, PW'(i) - rd_ptr_q} < count_q);
    end
  end

  assign head_o     = mem_q[rd_ptr_q];
  assign head_ptr_o = rd_ptr_q;
  assign count_o    = count_q;
  assign full_o     = (count_q == (PW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);

endmodule

// File: rtl/wb_write_queue.sv
// rtl/wb_write_queue.sv - arbitrates ALU/LSU writes, queues them and drives the regfile write port
module wb_write_queue
  import wb_pkg::*;
#(
  parameter int DW    = WB_DW,
  parameter int AW    = WB_AW,
  parameter int DEPTH = WB_DEPTH,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  wb_write_queue_if.slave bus
);

  wb_entry_t        head;
  wb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW:0]      count;
  logic [PW-1:0]    head_ptr;
  logic             full, empty;

  wb_entry_t        req;
  logic             lsu_fire, alu_fire, push_ok, pop, bypass, fifo_push;

  logic             we3_q, we3_d;
  logic [AW-1:0]    a3_q, a3_d;
  logic [DW-1:0]    wd3_q, wd3_d;

  logic             fwd_hit;
  logic [DW-1:0]    fwd_data;
  logic [PW-1:0]    slot;

  // Ready is a function of the registered count only, so a pop cannot free a slot in the same cycle.
  assign bus.lsu_ready = !rst && !full;
  assign bus.alu_ready = !rst && !full && !bus.lsu_valid;

  assign lsu_fire = bus.lsu_valid && bus.lsu_ready;
  assign alu_fire = bus.alu_valid && bus.alu_ready;

  always_comb begin
    req = '0;
    if (lsu_fire) begin
      req.rd   = bus.lsu_rd;
      req.data = bus.lsu_data;
    end else begin
      req.rd   = bus.alu_rd;
      req.data = bus.alu_data;
    end
  end

  assign push_ok   = (lsu_fire || alu_fire) && (req.rd != REG_ZERO);
  assign pop       = !bus.wb_hold && !empty;
  assign bypass    = !bus.wb_hold && empty && push_ok;
  assign fifo_push = push_ok && !bypass;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fifo_push),
    .din_i      (req),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count),
    .head_ptr_o (head_ptr),
    .entries_o  (entries),
    .valid_o    (valid),
    .full_o     (full),
    .empty_o    (empty)
  );

  always_comb begin
    we3_d = 1'b0;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (pop) begin
      we3_d = 1'b1;
      a3_d  = head.rd;
      wd3_d = head.data;
    end else if (bypass) begin
      we3_d = 1'b1;
      a3_d  = req.rd;
      wd3_d = req.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we3_q <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
    end else begin
      we3_q <= we3_d;
      a3_q  <= a3_d;
      wd3_q <= wd3_d;
    end
  end

  // Walk oldest to newest so the newest matching entry overrides older ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = '0;
    if (we3_q && (a3_q == bus.fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = wd3_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_ptr + PW'(k);
      if (valid[slot] && (entries[slot].rd == bus.fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[slot].data;
      end
    end
    if (bus.fwd_addr == REG_ZERO) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
  end

  assign bus.we3      = we3_q;
  assign bus.a3       = a3_q;
  assign bus.wd3      = wd3_q;
  assign bus.fwd_hit  = fwd_hit;
  assign bus.fwd_data = fwd_data;

endmodule

// File: tb/tb_wb_write_queue.sv
// tb/tb_wb_write_queue.sv - directed self-checking bench for wb_write_queue
module tb_wb_write_queue;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  wb_write_queue_if #(.DW(32), .AW(6)) bus ();

  wb_write_queue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_req(input logic v, input logic [5:0] rd, input logic [31:0] d);
    bus.alu_valid = v;
    bus.alu_rd    = rd;
    bus.alu_data  = d;
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [5:0] a, input logic [31:0] d);
    chk({tag, ".we3"}, 64'(bus.we3), 64'(we));
    chk({tag, ".a3"},  64'(bus.a3),  64'(a));
    chk({tag, ".wd3"}, 64'(bus.wd3), 64'(d));
  endtask

  initial begin
    rst           = 1'b1;
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.lsu_valid = 1'b0;
    bus.lsu_rd    = '0;
    bus.lsu_data  = '0;
    bus.wb_hold   = 1'b0;
    bus.fwd_addr  = '0;

    // reset state
    #7;
    chk_out("rst", 1'b0, 6'd0, 32'h0);
    chk("rst.alu_ready", 64'(bus.alu_ready), 64'd0);
    chk("rst.lsu_ready", 64'(bus.lsu_ready), 64'd0);
    #5 rst = 1'b0;
    #1;
    chk("rel.alu_ready", 64'(bus.alu_ready), 64'd1);
    chk("rel.lsu_ready", 64'(bus.lsu_ready), 64'd1);

    // single write, empty queue -> bypass
    @(negedge clk);
    alu_req(1'b1, 6'd9, 32'hABCDEF01);
    #1 chk("t2.alu_ready", 64'(bus.alu_ready), 64'd1);
    tick();
    alu_req(1'b0, 6'd0, 32'h0);
    bus.fwd_addr = 6'd9;
    #1;
    chk_out("t2.issue", 1'b1, 6'd9, 32'hABCDEF01);
    chk("t2.fwd_hit", 64'(bus.fwd_hit), 64'd1);
    chk("t2.fwd_data", 64'(bus.fwd_data), 64'hABCDEF01);
    tick();
    chk_out("t2.after", 1'b0, 6'd9, 32'hABCDEF01);
    chk("t2.fwd_gone", 64'(bus.fwd_hit), 64'd0);

    // simultaneous requests, LSU wins
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 6'd4;
    bus.lsu_data  = 32'h12345678;
    alu_req(1'b1, 6'd3, 32'hBABEFACE);
    #1;
    chk("t3.alu_ready", 64'(bus.alu_ready), 64'd0);
    chk("t3.lsu_ready", 64'(bus.lsu_ready), 64'd1);
    tick();
    bus.lsu_valid = 1'b0;
    #1;
    chk_out("t3.x4", 1'b1, 6'd4, 32'h12345678);
    chk("t3.alu_ready2", 64'(bus.alu_ready), 64'd1);
    tick();
    alu_req(1'b0, 6'd0, 32'h0);
    chk_out("t3.x3", 1'b1, 6'd3, 32'hBABEFACE);
    tick();
    chk("t3.idle", 64'(bus.we3), 64'd0);

    // zero register is accepted and dropped
    alu_req(1'b1, 6'd0, 32'hFFFFFFFF);
    bus.fwd_addr = 6'd0;
    #1;
    chk("t4.alu_ready", 64'(bus.alu_ready), 64'd1);
    tick();
    alu_req(1'b0, 6'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("t4.we3", 64'(bus.we3), 64'd0);
      chk("t4.fwd_hit", 64'(bus.fwd_hit), 64'd0);
      tick();
    end

    // hold, fill, forward, drain in order
    bus.wb_hold = 1'b1;
    alu_req(1'b1, 6'd9, 32'h11111111); #1 chk("t5.rdy0", 64'(bus.alu_ready), 64'd1); tick();
    alu_req(1'b1, 6'd9, 32'h22222222); #1 chk("t5.rdy1", 64'(bus.alu_ready), 64'd1); tick();
    alu_req(1'b1, 6'd5, 32'h55555555); #1 chk("t5.rdy2", 64'(bus.alu_ready), 64'd1); tick();
    alu_req(1'b1, 6'd6, 32'h66666666); #1 chk("t5.rdy3", 64'(bus.alu_ready), 64'd1); tick();
    alu_req(1'b1, 6'd7, 32'h77777777);
    #1;
    chk("t5.full_alu", 64'(bus.alu_ready), 64'd0);
    chk("t5.full_lsu", 64'(bus.lsu_ready), 64'd0);
    chk("t5.hold_we3", 64'(bus.we3), 64'd0);
    tick();
    alu_req(1'b0, 6'd0, 32'h0);
    bus.fwd_addr = 6'd9;
    #1;
    chk("t5.fwd9_hit", 64'(bus.fwd_hit), 64'd1);
    chk("t5.fwd9_data", 64'(bus.fwd_data), 64'h22222222);
    bus.fwd_addr = 6'd6;
    #1 chk("t5.fwd6_data", 64'(bus.fwd_data), 64'h66666666);
    bus.fwd_addr = 6'd7;
    #1;
    chk("t5.fwd7_hit", 64'(bus.fwd_hit), 64'd0);
    chk("t5.fwd7_data", 64'(bus.fwd_data), 64'd0);
    bus.wb_hold  = 1'b0;
    bus.fwd_addr = 6'd9;
    tick();
    chk_out("t5.pop0", 1'b1, 6'd9, 32'h11111111);
    chk("t5.fwd_newest", 64'(bus.fwd_data), 64'h22222222);
    tick();
    chk_out("t5.pop1", 1'b1, 6'd9, 32'h22222222);
    tick();
    chk_out("t5.pop2", 1'b1, 6'd5, 32'h55555555);
    tick();
    chk_out("t5.pop3", 1'b1, 6'd6, 32'h66666666);
    tick();
    chk("t5.drained", 64'(bus.we3), 64'd0);

    // reset mid-operation discards queued entries
    bus.wb_hold = 1'b1;
    alu_req(1'b1, 6'd5, 32'h5A5A5A5A); tick();
    alu_req(1'b1, 6'd6, 32'h6A6A6A6A); tick();
    alu_req(1'b1, 6'd7, 32'h7A7A7A7A); tick();
    alu_req(1'b0, 6'd0, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk_out("t6.rst", 1'b0, 6'd0, 32'h0);
    chk("t6.rst_alu_ready", 64'(bus.alu_ready), 64'd0);
    chk("t6.rst_lsu_ready", 64'(bus.lsu_ready), 64'd0);
    #1 rst = 1'b0;
    bus.wb_hold  = 1'b0;
    bus.fwd_addr = 6'd5;
    #1;
    chk("t6.fwd5_hit", 64'(bus.fwd_hit), 64'd0);
    chk("t6.alu_ready", 64'(bus.alu_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6.no_we3", 64'(bus.we3), 64'd0);
    end
    alu_req(1'b1, 6'd1, 32'h00000001);
    tick();
    alu_req(1'b0, 6'd0, 32'h0);
    chk_out("t6.fresh", 1'b1, 6'd1, 32'h00000001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_write_queue.md
# wb_write_queue

Writeback-side producer for the `regfile` write port (`we3`/`a3`/`wd3`) in the single-cycle RISC-V core. It accepts register-write requests from two sources, the ALU and the load/store unit (LSU), over valid/ready handshakes. It buffers them in a small in-order queue and issues at most one regfile write per cycle. A combinational forwarding port lets the operand-read side see queued values that have not yet reached the register file.

## Interface

Parameters:

- `DW`, 32, data width
- `AW`, 6, register address width (matches `regfile` `a1`/`a2`/`a3`)
- `DEPTH`, 4, queue entries (power of 2, ≥2)

Ports:

- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `alu_valid`  in  1  ALU write request
- `alu_ready`  out  1  ALU request accepted this cycle
- `alu_rd`  in  AW  ALU destination register
- `alu_data`  in  DW  ALU result
- `lsu_valid`  in  1  LSU write request
- `lsu_ready`  out  1  LSU request accepted this cycle
- `lsu_rd`  in  AW  LSU destination register
- `lsu_data`  in  DW  load data
- `wb_hold`  in  1  stall regfile writes (port borrowed)
- `we3`  out  1  regfile write enable, registered
- `a3`  out  AW  regfile write address, registered
- `wd3`  out  DW  regfile write data, registered
- `fwd_addr`  in  AW  read-side lookup address
- `fwd_hit`  out  1  a pending write to `fwd_addr` exists
- `fwd_data`  out  DW  newest pending data for `fwd_addr`

## Operation

- Arbitration: fixed priority, LSU over ALU.
  - `lsu_ready = !full`.
  - `alu_ready = !full && !lsu_valid`.
  - At most one push per cycle.
- Handshake: transfer occurs on an edge where valid and ready are both high. Ready depends only on registered `count` and on `lsu_valid`, never on `wb_hold`.
- Writes with `rd == 0` are accepted and discarded. They are never enqueued and never pulse `we3`.
- Issue on each edge, when `wb_hold = 0`:
  - If the queue is non-empty, pop the head into `a3`/`wd3` and set `we3 = 1`.
  - If the queue is empty and a push occurs this edge, the request bypasses the queue straight into `a3`/`wd3` with `we3 = 1`.
  - Otherwise `we3 = 0`.
- When `wb_hold = 1`: no pop and no bypass. `we3 = 0` at the next edge, `a3`/`wd3` keep their values, and pushes still enqueue.
- Push and pop may occur on the same edge. `count` is unchanged in that case, and the pushed entry goes to the tail.
- Ordering: regfile writes occur strictly in acceptance order.
- Forwarding (combinational):
  - Search, newest first: queue tail → head, then the output register when `we3 = 1`.
  - The first `rd` match gives `fwd_hit = 1` and `fwd_data` from that entry.
  - `fwd_addr == 0` or no match gives `fwd_hit = 0` and `fwd_data = 0`.
- Full/empty:
  - `full = (count == DEPTH)`.
  - Pointers wrap modulo `DEPTH`.
  - `count` is `$clog2(DEPTH)+1` bits wide.

## Timing

- Reset values (asynchronous assert):
  - `we3 = 0`, `a3 = 0`, `wd3 = 0`, `count = 0`, pointers `= 0`.
  - `alu_ready` and `lsu_ready` forced 0 while `rst` is high.
- Reset mid-operation discards all queued entries and any in-flight output. No `we3` pulse may follow from pre-reset requests.
- Latency, queue empty and no hold: request accepted at edge N → `we3 = 1` with its `a3`/`wd3` during cycle N..N+1 → regfile write at edge N+1.
- Latency, queued behind k entries with no hold: `we3` pulse k cycles later than the bypass case.
- `we3` is a one-cycle pulse per entry.
- Back-to-back entries produce consecutive `we3`-high cycles.
- Throughput: 1 write/cycle sustained.

## Structure

- Shared package `wb_pkg`:
  - default `DW`/`AW`/`DEPTH` constants
  - packed struct `wb_entry_t {rd[AW], data[DW]}`
  - `REG_ZERO` constant
- Sub-module `wb_fifo`:
  - synchronous circular buffer of `wb_entry_t`, with push/pop and `count`
  - exposes all entries plus valid bits for the forward search
- Top level holds: arbitration, zero-register drop, bypass, output register, forward priority mux.

## Test plan

1. Reset: assert `rst` asynchronously mid-cycle → `we3`/`a3`/`wd3 = 0` immediately and both readys 0; after release, both readys 1 at the first edge.
2. Single write, empty queue: ALU `rd = 9`, data `0xABCDEF01` accepted at edge N → during N..N+1 `we3 = 1`, `a3 = 9`, `wd3 = 0xABCDEF01`; after N+1 `we3 = 0`.
3. Simultaneous requests: LSU `rd = 4`, `0x12345678` and ALU `rd = 3`, `0xBABEFACE` → `alu_ready = 0` in the first cycle; writes issue x4 then x3 on consecutive cycles.
4. Zero register: ALU `rd = 0`, data `0xFFFFFFFF` → `alu_ready = 1`, and `we3` stays 0 for the following 3 cycles.
5. Hold and full (`DEPTH = 4`): `wb_hold = 1`, push five requests (x9 `0x11111111`, x9 `0x22222222`, x5, x6, x7) → four accepted and readys 0 on the fifth.
   - `fwd_addr = 9` → `fwd_hit = 1`, `fwd_data = 0x22222222`.
   - Release hold → four consecutive `we3` pulses in order.
6. Reset mid-operation: three entries queued under hold, pulse `rst` → after release, no `we3` pulse while hold is low, and `fwd_hit = 0` for x5.
